// File: rtl/javk_alu_ctrl.sv
// JAVK execution core: instruction decoder plus 8-bit ALU on accumulator A.
// Holds the {V,N,C,Z} flags that steer conditional jumps.
module javk_alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] alu_out,
  output logic [3:0] flags,
  output logic       alu_we,
  output logic [3:0] reg_sel,
  output logic [3:0] addr_offset,
  output logic       fetch,
  output logic       we,
  output logic       jmp,
  output logic       jpl,
  output logic       branch,
  output logic       mva,
  output logic       mvb,
  output logic [1:0] reg16_dst,
  output logic [1:0] reg16_src,
  output logic       nibble_read,
  output logic       nibble_hl,
  output logic [3:0] nibble_out
);

  logic [3:0] op;
  logic [3:0] n;
  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [7:0] res;
  logic [8:0] sum;
  logic       cOut;
  logic       vOut;
  logic       cond;
  logic       aluWeRaw, fetchRaw, weRaw, jmpRaw, jplRaw, branchRaw;
  logic       mvaRaw, mvbRaw, nibReadRaw;

  assign op = instr[7:4];
  assign n  = instr[3:0];

  always_comb begin
    res  = 8'h00;
    sum  = 9'h000;
    cOut = 1'b0;
    vOut = 1'b0;
    case (op)
      4'h1: begin
        sum  = {1'b0, a} + {1'b0, b};
        res  = sum[7:0];
        cOut = sum[8];
        vOut = (a[7] == b[7]) && (res[7] != a[7]);
      end
      4'h2: begin
        // Ninth bit of the 9-bit difference is the borrow (a < b).
        sum  = {1'b0, a} - {1'b0, b};
        res  = sum[7:0];
        cOut = sum[8];
        vOut = (a[7] != b[7]) && (res[7] != a[7]);
      end
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = a ^ b;
      4'h6: begin
        res = (n < 4'd8) ? (a << n[2:0]) : 8'h00;
        if (n != 4'd0 && n <= 4'd8) cOut = a[3'(4'd8 - n)];
      end
      4'h7: begin
        res = (n < 4'd8) ? (a >> n[2:0]) : 8'h00;
        if (n != 4'd0 && n <= 4'd8) cOut = a[3'(n - 4'd1)];
      end
      4'h8: begin
        res  = 8'(({a, a}) >> n[2:0]);
        cOut = (n[2:0] != 3'd0) && res[7];
      end
      default: res = 8'h00;
    endcase
  end

  assign flags_d = {vOut, res[7], cOut, (res == 8'h00)};

  // Condition is evaluated on the flags from the previous ALU instruction.
  always_comb begin
    case (instr[2:0])
      3'd0:    cond = 1'b1;
      3'd1:    cond = flags_q[0];
      3'd2:    cond = !flags_q[0];
      3'd3:    cond = flags_q[1];
      3'd4:    cond = !flags_q[1];
      3'd5:    cond = flags_q[2];
      3'd6:    cond = !flags_q[2];
      default: cond = flags_q[3];
    endcase
  end

  always_comb begin
    aluWeRaw    = 1'b0;
    fetchRaw    = 1'b0;
    weRaw       = 1'b0;
    jmpRaw      = 1'b0;
    jplRaw      = 1'b0;
    branchRaw   = 1'b0;
    mvaRaw      = 1'b0;
    mvbRaw      = 1'b0;
    nibReadRaw  = 1'b0;
    reg_sel     = 4'h0;
    addr_offset = 4'h0;
    reg16_dst   = 2'd0;
    reg16_src   = 2'd0;
    nibble_hl   = 1'b0;
    nibble_out  = 4'h0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        aluWeRaw = 1'b1;
        reg_sel  = n;
      end
      4'h6, 4'h7, 4'h8: aluWeRaw = 1'b1;
      4'h9: begin
        mvaRaw  = 1'b1;
        reg_sel = n;
      end
      4'hA, 4'hB: begin
        nibReadRaw = 1'b1;
        nibble_out = n;
        nibble_hl  = op[0];
      end
      4'hC, 4'hD: begin
        fetchRaw    = 1'b1;
        addr_offset = n;
        weRaw       = op[0];
      end
      4'hE: begin
        jplRaw    = instr[3];
        jmpRaw    = !instr[3];
        branchRaw = cond;
      end
      4'hF: begin
        mvbRaw    = 1'b1;
        reg16_dst = instr[3:2];
        reg16_src = instr[1:0];
      end
      default: ;
    endcase
  end

  // Strobes are held off during reset; the data outputs keep decoding.
  assign alu_we      = aluWeRaw   & rst;
  assign fetch       = fetchRaw   & rst;
  assign we          = weRaw      & rst;
  assign jmp         = jmpRaw     & rst;
  assign jpl         = jplRaw     & rst;
  assign branch      = branchRaw  & rst;
  assign mva         = mvaRaw     & rst;
  assign mvb         = mvbRaw     & rst;
  assign nibble_read = nibReadRaw & rst;
  assign alu_out     = res;
  assign flags       = flags_q;

  always_ff @(posedge clk) begin
    if (!rst)        flags_q <= 4'h0;
    else if (alu_we) flags_q <= flags_d;
  end

endmodule

// File: tb/tb_javk_alu_ctrl.sv
// Scoreboard bench for javk_alu_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every output.
module tb_javk_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr, a, b;
  logic [7:0] alu_out;
  logic [3:0] flags, reg_sel, addr_offset, nibble_out;
  logic       alu_we, fetch, we, jmp, jpl, branch, mva, mvb;
  logic [1:0] reg16_dst, reg16_src;
  logic       nibble_read, nibble_hl;

  typedef struct packed {
    logic [7:0] aluOut;
    logic [3:0] flags;
    logic       aluWe;
    logic [3:0] regSel;
    logic [3:0] addrOffset;
    logic       fetch, we, jmp, jpl, branch, mva, mvb;
    logic [1:0] dst, src;
    logic       nibRead, nibHl;
    logic [3:0] nibOut;
  } expect_t;

  expect_t expQ[$];
  expect_t e;
  int vectors = 0;
  int miscompares = 0;

  javk_alu_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .a(a), .b(b),
    .alu_out(alu_out), .flags(flags), .alu_we(alu_we), .reg_sel(reg_sel),
    .addr_offset(addr_offset), .fetch(fetch), .we(we), .jmp(jmp), .jpl(jpl),
    .branch(branch), .mva(mva), .mvb(mvb), .reg16_dst(reg16_dst),
    .reg16_src(reg16_src), .nibble_read(nibble_read), .nibble_hl(nibble_hl),
    .nibble_out(nibble_out)
  );

  always #5 clk = ~clk;

  function automatic expect_t blank(input logic [3:0] f);
    expect_t x;
    x = '0;
    x.flags = f;
    return x;
  endfunction

  function automatic void cmp(input string name, input logic [7:0] act,
                              input logic [7:0] req, input logic [7:0] ins);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s (instr %02h): got %02h, expected %02h", name, ins, act, req);
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic [7:0] i,
                               input logic [7:0] va, input logic [7:0] vb,
                               input expect_t x);
    @(posedge clk);
    #1;
    rst = r; instr = i; a = va; b = vb;
    expQ.push_back(x);
  endtask

  task automatic checkOutput(input expect_t x);
    vectors++;
    cmp("alu_out", alu_out, x.aluOut, instr);
    cmp("flags", {4'h0, flags}, {4'h0, x.flags}, instr);
    cmp("alu_we", {7'h0, alu_we}, {7'h0, x.aluWe}, instr);
    cmp("reg_sel", {4'h0, reg_sel}, {4'h0, x.regSel}, instr);
    cmp("addr_offset", {4'h0, addr_offset}, {4'h0, x.addrOffset}, instr);
    cmp("fetch", {7'h0, fetch}, {7'h0, x.fetch}, instr);
    cmp("we", {7'h0, we}, {7'h0, x.we}, instr);
    cmp("jmp", {7'h0, jmp}, {7'h0, x.jmp}, instr);
    cmp("jpl", {7'h0, jpl}, {7'h0, x.jpl}, instr);
    cmp("branch", {7'h0, branch}, {7'h0, x.branch}, instr);
    cmp("mva", {7'h0, mva}, {7'h0, x.mva}, instr);
    cmp("mvb", {7'h0, mvb}, {7'h0, x.mvb}, instr);
    cmp("reg16_dst", {6'h0, reg16_dst}, {6'h0, x.dst}, instr);
    cmp("reg16_src", {6'h0, reg16_src}, {6'h0, x.src}, instr);
    cmp("nibble_read", {7'h0, nibble_read}, {7'h0, x.nibRead}, instr);
    cmp("nibble_hl", {7'h0, nibble_hl}, {7'h0, x.nibHl}, instr);
    cmp("nibble_out", {4'h0, nibble_out}, {4'h0, x.nibOut}, instr);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    rst = 1'b0; instr = 8'h00; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);

    // Reset with an ALU op present: strobes off, flags cleared.
    e = blank(4'b0000); e.aluOut = 8'h80; e.regSel = 4'h3;
    applyStimulus(1'b0, 8'h13, 8'h7F, 8'h01, e);
    e = blank(4'b0000); e.aluOut = 8'h80; e.regSel = 4'h3; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h13, 8'h7F, 8'h01, e);
    // Flags hold 1100 across non-ALU instructions.
    e = blank(4'b1100);
    applyStimulus(1'b1, 8'h00, 8'h7F, 8'h01, e);
    e = blank(4'b1100); e.mva = 1'b1; e.regSel = 4'hD;
    applyStimulus(1'b1, 8'h9D, 8'h7F, 8'h01, e);
    e = blank(4'b1100); e.fetch = 1'b1; e.addrOffset = 4'h5;
    applyStimulus(1'b1, 8'hC5, 8'h7F, 8'h01, e);
    e = blank(4'b1100); e.aluWe = 1'b1; e.regSel = 4'hC;
    applyStimulus(1'b1, 8'h2C, 8'h05, 8'h05, e);
    e = blank(4'b0001); e.jmp = 1'b1; e.branch = 1'b1;
    applyStimulus(1'b1, 8'hE1, 8'h05, 8'h05, e);
    e = blank(4'b0001); e.jmp = 1'b1;
    applyStimulus(1'b1, 8'hE2, 8'h05, 8'h05, e);
    e = blank(4'b0001); e.jpl = 1'b1; e.branch = 1'b1;
    applyStimulus(1'b1, 8'hE8, 8'h05, 8'h05, e);
    // Shifts on a = 0x81.
    e = blank(4'b0001); e.aluOut = 8'h02; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h61, 8'h81, 8'h00, e);
    e = blank(4'b0010); e.aluOut = 8'h00; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h69, 8'h81, 8'h00, e);
    e = blank(4'b0001); e.aluOut = 8'h18; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h84, 8'h81, 8'h00, e);
    e = blank(4'b0000); e.aluOut = 8'h40; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h71, 8'h81, 8'h00, e);
    e = blank(4'b0010); e.jmp = 1'b1; e.branch = 1'b1;
    applyStimulus(1'b1, 8'hE3, 8'h81, 8'h00, e);
    // Memory, moves, nibble loads.
    e = blank(4'b0010); e.fetch = 1'b1; e.we = 1'b1; e.addrOffset = 4'h7;
    applyStimulus(1'b1, 8'hD7, 8'h81, 8'h00, e);
    e = blank(4'b0010); e.mvb = 1'b1; e.dst = 2'd2; e.src = 2'd0;
    applyStimulus(1'b1, 8'hF8, 8'h81, 8'h00, e);
    e = blank(4'b0010); e.nibRead = 1'b1; e.nibHl = 1'b1; e.nibOut = 4'hA;
    applyStimulus(1'b1, 8'hBA, 8'h81, 8'h00, e);
    e = blank(4'b0010); e.nibRead = 1'b1; e.nibOut = 4'h3;
    applyStimulus(1'b1, 8'hA3, 8'h81, 8'h00, e);
    // Carry, borrow, logic ops, overflow cases.
    e = blank(4'b0010); e.aluOut = 8'h00; e.aluWe = 1'b1; e.regSel = 4'h1;
    applyStimulus(1'b1, 8'h11, 8'hFF, 8'h01, e);
    e = blank(4'b0011); e.aluOut = 8'hFE; e.aluWe = 1'b1; e.regSel = 4'h2;
    applyStimulus(1'b1, 8'h22, 8'h03, 8'h05, e);
    e = blank(4'b0110); e.aluOut = 8'h30; e.aluWe = 1'b1; e.regSel = 4'hF;
    applyStimulus(1'b1, 8'h3F, 8'hF0, 8'h3C, e);
    e = blank(4'b0000); e.aluOut = 8'h81; e.aluWe = 1'b1; e.regSel = 4'h0;
    applyStimulus(1'b1, 8'h40, 8'h80, 8'h01, e);
    e = blank(4'b0100); e.aluOut = 8'h00; e.aluWe = 1'b1; e.regSel = 4'h5;
    applyStimulus(1'b1, 8'h55, 8'hAA, 8'hAA, e);
    e = blank(4'b0001); e.jmp = 1'b1;
    applyStimulus(1'b1, 8'hE5, 8'hAA, 8'hAA, e);
    e = blank(4'b0001); e.aluOut = 8'h00; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h78, 8'h81, 8'h00, e);
    e = blank(4'b0011); e.aluOut = 8'h7F; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h20, 8'h80, 8'h01, e);
    e = blank(4'b1000); e.jpl = 1'b1; e.branch = 1'b1;
    applyStimulus(1'b1, 8'hEF, 8'h80, 8'h01, e);
    // Reset wins over a concurrent ALU op and masks jump strobes.
    e = blank(4'b1000); e.aluOut = 8'h80; e.regSel = 4'h3;
    applyStimulus(1'b0, 8'h13, 8'h7F, 8'h01, e);
    e = blank(4'b0000);
    applyStimulus(1'b0, 8'hE0, 8'h7F, 8'h01, e);
    e = blank(4'b0000); e.aluOut = 8'h81; e.aluWe = 1'b1;
    applyStimulus(1'b1, 8'h80, 8'h81, 8'h00, e);
    e = blank(4'b0100);
    applyStimulus(1'b1, 8'h00, 8'h81, 8'h00, e);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
